// File: rtl/rdma_cq_receiver_pkg.sv
// Shared types and constants for the RDMA completion-queue receiver.
// The entry struct reflects the default 16-bit wr_id width.
package rdma_cq_pkg;

    localparam int CQ_WRID_W = 16;

    localparam logic [1:0] CQ_ST_OK        = 2'd0;
    localparam logic [1:0] CQ_ST_REM_ERR   = 2'd1;
    localparam logic [1:0] CQ_ST_LOC_ERR   = 2'd2;
    localparam logic [1:0] CQ_ST_RETRY_EXC = 2'd3;

    typedef struct packed {
        logic [CQ_WRID_W-1:0] wr_id;
        logic [1:0]           status;
    } cq_entry_t;

    typedef enum logic {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } mod_state_e;

endpackage

// File: rtl/rdma_cq_receiver_if.sv
// Completion-in / poll-out bundle between the completion generator, the CQ and the host.
interface rdma_cq_if #(parameter int WRID_W = 16) ();

    logic              comp_valid;
    logic [WRID_W-1:0] comp_wr_id;
    logic [1:0]        comp_status;
    logic              poll_valid;
    logic [WRID_W-1:0] poll_wr_id;
    logic [1:0]        poll_status;
    logic              poll_ready;

    modport master (
        output comp_valid, comp_wr_id, comp_status, poll_ready,
        input  poll_valid, poll_wr_id, poll_status
    );

    modport slave (
        input  comp_valid, comp_wr_id, comp_status, poll_ready,
        output poll_valid, poll_wr_id, poll_status
    );

endinterface

// File: rtl/rdma_cq_receiver_fifo.sv
// First-word-fall-through storage for the completion queue.
// The caller guarantees no push when full unless a pop happens in the same cycle.
module rdma_cq_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 18
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Storage, pointers (wrap modulo DEPTH) and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == FULL_CNT);
    assign empty = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/rdma_cq_receiver.sv
// Host-side completion receiver: CQ buffering, sticky overflow flag and
// moderated interrupt (threshold, timeout, or immediate on error status).
module rdma_cq_receiver
    import rdma_cq_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WRID_W      = 16,
    parameter int INT_THRESH  = 4,
    parameter int INT_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rdma_cq_if.slave               cq,
    output logic [$clog2(DEPTH):0] cq_count,
    output logic                   cq_overflow,
    input  logic                   ovf_clr,
    output logic                   irq
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int PEND_W = CNT_W;
    localparam int TMR_W  = $clog2(INT_TIMEOUT) + 1;
    localparam logic [PEND_W-1:0] THRESH_P = PEND_W'(INT_THRESH);
    localparam logic [TMR_W-1:0]  TMO_HIT  = TMR_W'(INT_TIMEOUT - 2);

    logic [WRID_W+1:0] rdata_s;
    logic [CNT_W-1:0]  cnt_s;
    logic              full_s, empty_s;
    logic              push_s, pop_s, drop_s, drained_s;
    logic              err_s, thr_s, tmo_s, fire_s;
    logic [PEND_W-1:0] pend_sum_s, pending_nxt_s, pending_r;
    logic [TMR_W-1:0]  timer_nxt_s, timer_r;
    mod_state_e        state_nxt_s, state_r;
    logic              ovf_r, irq_r;

    assign pop_s  = !empty_s && cq.poll_ready;
    assign push_s = cq.comp_valid && (!full_s || pop_s);
    assign drop_s = cq.comp_valid && full_s && !pop_s;

    rdma_cq_fifo #(.DEPTH(DEPTH), .WIDTH(WRID_W + 2)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({cq.comp_wr_id, cq.comp_status}),
        .rdata (rdata_s),
        .count (cnt_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign cq.poll_valid  = !empty_s;
    assign cq.poll_wr_id  = rdata_s[WRID_W+1:2];
    assign cq.poll_status = rdata_s[1:0];
    assign cq_count       = cnt_s;
    assign cq_overflow    = ovf_r;
    assign irq            = irq_r;

    // Fire conditions; only the timer-driven fire lets a coincident push start a new batch.
    always_comb begin
        pend_sum_s = PEND_W'(push_s);
        if (state_r == COUNTING) begin
            pend_sum_s = pending_r + PEND_W'(push_s);
        end else begin
            pend_sum_s = PEND_W'(push_s);
        end
        err_s     = push_s && (cq.comp_status != CQ_ST_OK);
        thr_s     = (pend_sum_s >= THRESH_P);
        tmo_s     = (state_r == COUNTING) && (timer_r == TMO_HIT);
        fire_s    = err_s || thr_s || tmo_s;
        drained_s = (cnt_s == {CNT_W{1'b0}}) || ((cnt_s == CNT_W'(1)) && pop_s);
    end

    // Moderation next-state logic.
    always_comb begin
        state_nxt_s   = state_r;
        pending_nxt_s = pending_r;
        timer_nxt_s   = timer_r;
        case (state_r)
            IDLE: begin
                timer_nxt_s = {TMR_W{1'b0}};
                if (fire_s) begin
                    state_nxt_s   = IDLE;
                    pending_nxt_s = {PEND_W{1'b0}};
                end else if (push_s) begin
                    state_nxt_s   = COUNTING;
                    pending_nxt_s = PEND_W'(1);
                end else begin
                    pending_nxt_s = {PEND_W{1'b0}};
                end
            end
            COUNTING: begin
                if (fire_s && push_s && !err_s && !thr_s) begin
                    state_nxt_s   = COUNTING;
                    pending_nxt_s = PEND_W'(1);
                    timer_nxt_s   = {TMR_W{1'b0}};
                end else if (fire_s || (!push_s && drained_s)) begin
                    state_nxt_s   = IDLE;
                    pending_nxt_s = {PEND_W{1'b0}};
                    timer_nxt_s   = {TMR_W{1'b0}};
                end else begin
                    pending_nxt_s = pend_sum_s;
                    timer_nxt_s   = timer_r + TMR_W'(1);
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                pending_nxt_s = {PEND_W{1'b0}};
                timer_nxt_s   = {TMR_W{1'b0}};
            end
        endcase
    end

    // Moderation state, interrupt pulse and sticky overflow (a new drop beats ovf_clr).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            pending_r <= {PEND_W{1'b0}};
            timer_r   <= {TMR_W{1'b0}};
            irq_r     <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pending_r <= pending_nxt_s;
            timer_r   <= timer_nxt_s;
            irq_r     <= fire_s;
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

endmodule

// File: tb/tb_rdma_cq_receiver.sv
// Scoreboard bench for rdma_cq_receiver: expected entries queued on push, compared as they are polled.
module tb_rdma_cq_receiver;
    import rdma_cq_pkg::*;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ovf_clr;
    logic [4:0] cq_count;
    logic       cq_overflow;
    logic       irq;

    rdma_cq_if #(.WRID_W(16)) cif ();

    rdma_cq_receiver #(.DEPTH(DEPTH), .WRID_W(16), .INT_THRESH(4), .INT_TIMEOUT(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cq          (cif.slave),
        .cq_count    (cq_count),
        .cq_overflow (cq_overflow),
        .ovf_clr     (ovf_clr),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int irq_cnt = 0;
    int irq_cyc = -1;
    cq_entry_t exp_q[$];
    cq_entry_t got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every polled entry and every irq pulse away from the active edge.
    always @(negedge clk) begin
        if (cif.poll_valid && cif.poll_ready) got_q.push_back(cq_entry_t'{wr_id: cif.poll_wr_id, status: cif.poll_status});
        if (irq === 1'b1) begin
            irq_cnt++;
            irq_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] id, input logic [1:0] st, output int c);
        cif.comp_valid  = 1'b1;
        cif.comp_wr_id  = id;
        cif.comp_status = st;
        c = cyc;
        tick();
        cif.comp_valid  = 1'b0;
        cif.comp_wr_id  = 16'h0000;
        cif.comp_status = 2'd0;
    endtask

    task automatic drain();
        cif.poll_ready = 1'b1;
        for (int i = 0; i < 40 && cif.poll_valid; i++) tick();
        cif.poll_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ovf_clr = 1'b0;
        cif.comp_valid = 1'b0; cif.comp_wr_id = 16'h0000; cif.comp_status = 2'd0; cif.poll_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++; if (cif.poll_valid !== 1'b0) begin failures++; $display("FAIL reset_poll_valid got=%b exp=0", cif.poll_valid); end
        checks++; if (cif.poll_wr_id !== 16'h0000 || cif.poll_status !== 2'd0) begin failures++; $display("FAIL reset_poll_data got=%h/%h exp=0/0", cif.poll_wr_id, cif.poll_status); end
        checks++; if (cq_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cq_count); end
        checks++; if (cq_overflow !== 1'b0 || irq !== 1'b0) begin failures++; $display("FAIL reset_flags got=ovf%b irq%b exp=0,0", cq_overflow, irq); end
    endtask

    task automatic test_single();
        int c, base;
        base = irq_cnt;
        cif.poll_ready = 1'b1;
        exp_q.push_back(cq_entry_t'{wr_id: 16'h0011, status: 2'd0});
        cif.comp_valid = 1'b1; cif.comp_wr_id = 16'h0011; cif.comp_status = 2'd0;
        tick();
        cif.comp_valid = 1'b0;
        checks++; if (cif.poll_valid !== 1'b1 || cif.poll_wr_id !== 16'h0011) begin failures++; $display("FAIL single_latency got=v%b id%h exp=v1 id0011", cif.poll_valid, cif.poll_wr_id); end
        tick();
        cif.poll_ready = 1'b0;
        checks++; if (cq_count !== 5'd0) begin failures++; $display("FAIL single_count got=%0d exp=0", cq_count); end
        repeat (80) tick();
        checks++; if (irq_cnt !== base) begin failures++; $display("FAIL single_no_irq got=%0d exp=%0d", irq_cnt, base); end
        while (exp_q.size() > 0) begin
            cq_entry_t e = exp_q.pop_front();
            checks++; if (got_q.size() == 0 || got_q[0] !== e) begin failures++; $display("FAIL single_order got_n=%0d exp=%h", got_q.size(), e); end
            if (got_q.size() > 0) void'(got_q.pop_front());
        end
        c = 0;
    endtask

    task automatic test_threshold();
        int c, base;
        base = irq_cnt;
        for (int i = 1; i <= 4; i++) begin
            send(16'(i), 2'd0, c);
            exp_q.push_back(cq_entry_t'{wr_id: 16'(i), status: 2'd0});
        end
        repeat (3) tick();
        checks++; if (irq_cnt !== base + 1) begin failures++; $display("FAIL thresh_irq_count got=%0d exp=%0d", irq_cnt - base, 1); end
        checks++; if (irq_cyc !== c + 1) begin failures++; $display("FAIL thresh_irq_cycle got=%0d exp=%0d", irq_cyc, c + 1); end
        checks++; if (cq_count !== 5'd4) begin failures++; $display("FAIL thresh_count got=%0d exp=4", cq_count); end
        drain();
        while (exp_q.size() > 0) begin
            cq_entry_t e = exp_q.pop_front();
            checks++; if (got_q.size() == 0 || got_q[0] !== e) begin failures++; $display("FAIL thresh_order got_n=%0d exp=%h", got_q.size(), e); end
            if (got_q.size() > 0) void'(got_q.pop_front());
        end
    endtask

    task automatic test_timeout();
        int c, base;
        base = irq_cnt;
        send(16'h0042, 2'd0, c);
        exp_q.push_back(cq_entry_t'{wr_id: 16'h0042, status: 2'd0});
        repeat (70) tick();
        checks++; if (irq_cnt !== base + 1) begin failures++; $display("FAIL timeout_irq_count got=%0d exp=1", irq_cnt - base); end
        checks++; if (irq_cyc !== c + 64) begin failures++; $display("FAIL timeout_irq_cycle got=%0d exp=%0d", irq_cyc, c + 64); end
        checks++; if (cq_count !== 5'd1) begin failures++; $display("FAIL timeout_count got=%0d exp=1", cq_count); end
        drain();
        while (exp_q.size() > 0) begin
            cq_entry_t e = exp_q.pop_front();
            checks++; if (got_q.size() == 0 || got_q[0] !== e) begin failures++; $display("FAIL timeout_order got_n=%0d exp=%h", got_q.size(), e); end
            if (got_q.size() > 0) void'(got_q.pop_front());
        end
    endtask

    task automatic test_overflow();
        int c;
        for (int i = 0; i < DEPTH; i++) begin
            send(16'(16'h0200 + i), 2'd0, c);
            exp_q.push_back(cq_entry_t'{wr_id: 16'(16'h0200 + i), status: 2'd0});
        end
        send(16'h0100, 2'd0, c);
        checks++; if (cq_count !== 5'd16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", cq_count); end
        checks++; if (cq_overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", cq_overflow); end
        ovf_clr = 1'b1;
        send(16'h0101, 2'd0, c);
        ovf_clr = 1'b0;
        checks++; if (cq_overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", cq_overflow); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++; if (cq_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", cq_overflow); end
        cif.poll_ready = 1'b1;
        send(16'h0300, 2'd0, c);
        cif.poll_ready = 1'b0;
        exp_q.push_back(cq_entry_t'{wr_id: 16'h0300, status: 2'd0});
        checks++; if (cq_count !== 5'd16 || cq_overflow !== 1'b0) begin failures++; $display("FAIL ovf_push_pop got=cnt%0d ovf%b exp=cnt16 ovf0", cq_count, cq_overflow); end
        drain();
        checks++; if (cq_count !== 5'd0) begin failures++; $display("FAIL ovf_drain got=%0d exp=0", cq_count); end
        while (exp_q.size() > 0) begin
            cq_entry_t e = exp_q.pop_front();
            checks++; if (got_q.size() == 0 || got_q[0] !== e) begin failures++; $display("FAIL ovf_order got_n=%0d exp=%h", got_q.size(), e); end
            if (got_q.size() > 0) void'(got_q.pop_front());
        end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL ovf_extra got=%0d exp=0", got_q.size()); end
    endtask

    task automatic test_error();
        int c, base;
        repeat (5) tick();
        base = irq_cnt;
        send(16'h0055, CQ_ST_LOC_ERR, c);
        exp_q.push_back(cq_entry_t'{wr_id: 16'h0055, status: CQ_ST_LOC_ERR});
        repeat (3) tick();
        checks++; if (irq_cnt !== base + 1) begin failures++; $display("FAIL err_irq_count got=%0d exp=1", irq_cnt - base); end
        checks++; if (irq_cyc !== c + 1) begin failures++; $display("FAIL err_irq_cycle got=%0d exp=%0d", irq_cyc, c + 1); end
        repeat (70) tick();
        checks++; if (irq_cnt !== base + 1) begin failures++; $display("FAIL err_back_idle got=%0d exp=1", irq_cnt - base); end
        drain();
        while (exp_q.size() > 0) begin
            cq_entry_t e = exp_q.pop_front();
            checks++; if (got_q.size() == 0 || got_q[0] !== e) begin failures++; $display("FAIL err_order got_n=%0d exp=%h", got_q.size(), e); end
            if (got_q.size() > 0) void'(got_q.pop_front());
        end
    endtask

    task automatic test_drain_no_irq();
        int c, base;
        base = irq_cnt;
        for (int i = 0; i < 3; i++) begin
            send(16'(16'h0A00 + i), 2'd0, c);
            exp_q.push_back(cq_entry_t'{wr_id: 16'(16'h0A00 + i), status: 2'd0});
        end
        drain();
        repeat (80) tick();
        checks++; if (irq_cnt !== base || cq_count !== 5'd0) begin failures++; $display("FAIL drain_no_irq got=irq%0d cnt%0d exp=irq0 cnt0", irq_cnt - base, cq_count); end
        while (exp_q.size() > 0) begin
            cq_entry_t e = exp_q.pop_front();
            checks++; if (got_q.size() == 0 || got_q[0] !== e) begin failures++; $display("FAIL drain_order got_n=%0d exp=%h", got_q.size(), e); end
            if (got_q.size() > 0) void'(got_q.pop_front());
        end
    endtask

    task automatic test_reset_mid();
        int c, base;
        for (int i = 0; i < 5; i++) send(16'(16'h0B00 + i), 2'd0, c);
        rst_n = 1'b0;
        #1;
        checks++; if (cq_count !== 5'd0 || cif.poll_valid !== 1'b0 || irq !== 1'b0 || cq_overflow !== 1'b0) begin failures++; $display("FAIL midrst_outputs got=cnt%0d v%b irq%b ovf%b exp=all0", cq_count, cif.poll_valid, irq, cq_overflow); end
        repeat (2) tick();
        rst_n = 1'b1;
        exp_q.delete();
        got_q.delete();
        base = irq_cnt;
        repeat (80) tick();
        checks++; if (irq_cnt !== base) begin failures++; $display("FAIL midrst_irq got=%0d exp=0", irq_cnt - base); end
        checks++; if (cq_count !== 5'd0 || cif.poll_valid !== 1'b0) begin failures++; $display("FAIL midrst_empty got=cnt%0d v%b exp=cnt0 v0", cq_count, cif.poll_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_threshold();
        test_timeout();
        test_overflow();
        test_error();
        test_drain_no_irq();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
